gcd_multi_core: RTL and testbench

GCD_MULTI_CORE -- requirements
Module: gcd_multi_core

---
 rtl/gcd_multi_core.sv | 134 +++++++++++++
 tb/tb_gcd_multi_core.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gcd_multi_core.sv
// Multi-operand GCD engine: operands are loaded into a small store, then reduced
// pairwise by repeated subtraction (acc = gcd(acc, op[k])) under an optional single-step enable.
module gcd_multi_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic             board_clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] Din,
    input  logic             Start,
    input  logic             Ack,
    input  logic             Step_mode,
    input  logic             CEN,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic [CNTW-1:0]  Iter_count,
    output logic [4:0]       Num_loaded,
    output logic             Full,
    output logic             Overflow,
    output logic             q_Init,
    output logic             q_Fetch,
    output logic             q_Sub,
    output logic             q_Done
);

    // state   | meaning
    // S_INIT  | accept operand loads, wait for Start
    // S_FETCH | copy acc and op[k] into the working pair A/B
    // S_SUB   | subtract smaller from larger until one is zero or both match
    // S_DONE  | Result holds the GCD, wait for Ack
    typedef enum logic [1:0] {S_INIT, S_FETCH, S_SUB, S_DONE} state_t;

    localparam logic [4:0] DEPTH_N = 5'(DEPTH);

    state_t           state;
    logic [WIDTH-1:0] op [0:15];
    logic [WIDTH-1:0] acc;
    logic [4:0]       k;

    logic             adv;
    logic             load_ok;
    logic [4:0]       n_eff;
    logic [WIDTH-1:0] op0_eff;
    logic [4:0]       k_next;
    logic [CNTW-1:0]  iter_inc;

    assign adv      = ~Step_mode | CEN;
    assign Full     = (Num_loaded == DEPTH_N);
    assign load_ok  = (state == S_INIT) & Load & ~Full;
    // A Load coinciding with Start counts toward this computation.
    assign n_eff    = Num_loaded + {4'd0, load_ok};
    assign op0_eff  = (Num_loaded == 5'd0 && load_ok) ? Din : op[0];
    assign k_next   = k + 5'd1;
    assign iter_inc = (&Iter_count) ? Iter_count : Iter_count + CNTW'(1);

    assign Result  = acc;
    assign q_Init  = (state == S_INIT);
    assign q_Fetch = (state == S_FETCH);
    assign q_Sub   = (state == S_SUB);
    assign q_Done  = (state == S_DONE);

    // Operand store carries no reset; contents are only meaningful below Num_loaded.
    always_ff @(posedge board_clk) begin
        if (load_ok && !Reset)
            op[Num_loaded[3:0]] <= Din;
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_INIT;
            A          <= '0;
            B          <= '0;
            acc        <= '0;
            k          <= '0;
            Iter_count <= '0;
            Num_loaded <= '0;
            Overflow   <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (load_ok)
                        Num_loaded <= Num_loaded + 5'd1;
                    else if (Load)
                        Overflow <= 1'b1;
                    if (Start) begin
                        Iter_count <= '0;
                        if (n_eff >= 5'd2) begin
                            acc   <= op0_eff;
                            k     <= 5'd1;
                            state <= S_FETCH;
                        end else begin
                            acc   <= (n_eff == 5'd1) ? op0_eff : '0;
                            state <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    if (adv) begin
                        A     <= acc;
                        B     <= op[k[3:0]];
                        state <= S_SUB;
                    end
                end
                S_SUB: begin
                    if (adv) begin
                        if (A != '0 && B != '0 && A > B) begin
                            A          <= A - B;
                            Iter_count <= iter_inc;
                        end else if (A != '0 && B != '0 && B > A) begin
                            B          <= B - A;
                            Iter_count <= iter_inc;
                        end else begin
                            acc   <= (A == '0) ? B : A;
                            k     <= k_next;
                            state <= (k_next < Num_loaded) ? S_FETCH : S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (Ack) begin
                        Num_loaded <= '0;
                        Overflow   <= 1'b0;
                        state      <= S_INIT;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_multi_core.sv
// Directed bench for gcd_multi_core: a vector table of operand sets with hand-computed
// GCD, subtraction count and Start-to-DONE latency, plus hand-written corner sequences.
module tb_gcd_multi_core;

    logic       board_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Load = 1'b0;
    logic [7:0] Din = '0;
    logic       Start = 1'b0;
    logic       Ack = 1'b0;
    logic       Step_mode = 1'b0;
    logic       CEN = 1'b0;
    logic [7:0] A, B, Result, Iter_count;
    logic [4:0] Num_loaded;
    logic       Full, Overflow, q_Init, q_Fetch, q_Sub, q_Done;

    int checks = 0;
    int errors = 0;

    gcd_multi_core #(.WIDTH(8), .DEPTH(4), .CNTW(8)) dut (
        .board_clk(board_clk), .Reset(Reset), .Load(Load), .Din(Din), .Start(Start),
        .Ack(Ack), .Step_mode(Step_mode), .CEN(CEN), .A(A), .B(B), .Result(Result),
        .Iter_count(Iter_count), .Num_loaded(Num_loaded), .Full(Full), .Overflow(Overflow),
        .q_Init(q_Init), .q_Fetch(q_Fetch), .q_Sub(q_Sub), .q_Done(q_Done)
    );

    always #5 board_clk = ~board_clk;

    typedef struct packed {
        logic [2:0]      n;
        logic [3:0][7:0] ops;
        logic [7:0]      res;
        logic [7:0]      iter;
        logic [15:0]     cyc;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(input int n, input int o0, input int o1, input int o2,
                                input int o3, input int res, input int iter, input int cyc);
        vec_t v;
        v.n      = 3'(n);
        v.ops[0] = 8'(o0);
        v.ops[1] = 8'(o1);
        v.ops[2] = 8'(o2);
        v.ops[3] = 8'(o3);
        v.res    = 8'(res);
        v.iter   = 8'(iter);
        v.cyc    = 16'(cyc);
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_load(input logic [7:0] d);
        Load = 1'b1;
        Din  = d;
        @(negedge board_clk);
        Load = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge board_clk);
        Start = 1'b0;
    endtask

    task automatic pulse_ack();
        Ack = 1'b1;
        @(negedge board_clk);
        Ack = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!q_Done && cyc < 2000) begin
            @(negedge board_clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;

        vecs[0] = mk(2, 12, 8, 0, 0, 4, 2, 5);
        vecs[1] = mk(3, 36, 24, 18, 0, 6, 4, 9);
        vecs[2] = mk(2, 0, 9, 0, 0, 9, 0, 3);
        vecs[3] = mk(1, 7, 0, 0, 0, 7, 0, 1);
        vecs[4] = mk(0, 0, 0, 0, 0, 0, 0, 1);
        vecs[5] = mk(2, 9, 0, 0, 0, 9, 0, 3);
        vecs[6] = mk(2, 17, 5, 0, 0, 1, 6, 9);
        vecs[7] = mk(4, 48, 36, 24, 12, 12, 4, 11);
        vecs[8] = mk(3, 255, 1, 255, 0, 1, 255, 513);

        #2;
        check("reset q_Init", q_Init, 1);
        check("reset q_Fetch", q_Fetch, 0);
        check("reset q_Sub", q_Sub, 0);
        check("reset q_Done", q_Done, 0);
        check("reset Result", Result, 0);
        check("reset Full", Full, 0);
        check("reset Num_loaded", Num_loaded, 0);
        @(negedge board_clk);
        Reset = 1'b0;
        @(negedge board_clk);

        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < int'(vecs[i].n); j++)
                pulse_load(vecs[i].ops[j]);
            check($sformatf("v%0d Num_loaded", i), Num_loaded, vecs[i].n);
            pulse_start();
            wait_done(cyc);
            check($sformatf("v%0d q_Done", i), q_Done, 1);
            check($sformatf("v%0d cycles", i), cyc, vecs[i].cyc);
            check($sformatf("v%0d Result", i), Result, vecs[i].res);
            check($sformatf("v%0d Iter_count", i), Iter_count, vecs[i].iter);
            pulse_ack();
            check($sformatf("v%0d ack q_Init", i), q_Init, 1);
            check($sformatf("v%0d ack Num_loaded", i), Num_loaded, 0);
        end

        // Load coinciding with Start joins the computation
        pulse_load(8'd12);
        Load = 1'b1; Din = 8'd8; Start = 1'b1;
        @(negedge board_clk);
        Load = 1'b0; Start = 1'b0;
        check("ldst Num_loaded", Num_loaded, 2);
        wait_done(cyc);
        check("ldst Result", Result, 4);
        // Load and Start are ignored in DONE
        pulse_load(8'd3);
        pulse_start();
        check("done load Num_loaded", Num_loaded, 2);
        check("done start q_Done", q_Done, 1);
        pulse_ack();

        // Overflow: fifth value must not be used
        pulse_load(8'd12);
        pulse_load(8'd8);
        pulse_load(8'd4);
        pulse_load(8'd16);
        check("pre-ovf Overflow", Overflow, 0);
        pulse_load(8'd3);
        check("ovf Num_loaded", Num_loaded, 4);
        check("ovf Full", Full, 1);
        check("ovf Overflow", Overflow, 1);
        pulse_start();
        wait_done(cyc);
        check("ovf Result", Result, 4);
        pulse_ack();
        check("ovf ack Overflow", Overflow, 0);
        check("ovf ack Full", Full, 0);

        // Single-step mode
        pulse_load(8'd12);
        pulse_load(8'd8);
        Step_mode = 1'b1;
        pulse_start();
        repeat (20) @(negedge board_clk);
        check("step held q_Fetch", q_Fetch, 1);
        pulse_ack();
        check("step ack ignored", q_Fetch, 1);
        CEN = 1'b1; @(negedge board_clk); CEN = 1'b0;
        check("step1 q_Sub", q_Sub, 1);
        check("step1 A", A, 12);
        check("step1 B", B, 8);
        repeat (3) @(negedge board_clk);
        check("step idle q_Sub", q_Sub, 1);
        for (int p = 0; p < 3; p++) begin
            CEN = 1'b1; @(negedge board_clk); CEN = 1'b0;
            @(negedge board_clk);
        end
        check("step q_Done", q_Done, 1);
        check("step Result", Result, 4);
        check("step Iter_count", Iter_count, 2);
        pulse_ack();
        Step_mode = 1'b0;

        // Reset in the middle of SUB
        pulse_load(8'd255);
        pulse_load(8'd1);
        pulse_start();
        repeat (10) @(negedge board_clk);
        check("mid q_Sub", q_Sub, 1);
        #2 Reset = 1'b1;
        #1;
        check("rst q_Init", q_Init, 1);
        check("rst q_Sub", q_Sub, 0);
        check("rst Iter_count", Iter_count, 0);
        check("rst A", A, 0);
        check("rst B", B, 0);
        check("rst Num_loaded", Num_loaded, 0);
        check("rst Result", Result, 0);
        @(negedge board_clk);
        Reset = 1'b0;
        @(negedge board_clk);
        pulse_start();
        check("empty q_Done", q_Done, 1);
        check("empty Result", Result, 0);
        pulse_ack();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
